// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared pipeline constants.
// Holds the default register-address width and the E-stage operand-forward
// select encodings used by the hazard unit and the E-stage operand muxes.
package riscv_pipe_pkg;
    localparam int REG_ADDR_W = 5;
    typedef enum logic [1:0] {
        FWD_RD   = 2'b00,
        FWD_RESW = 2'b01,
        FWD_FUM  = 2'b10
    } fwd_sel_e;
endpackage

// File: rtl/fwd_sel_logic.sv
// fwd_sel_logic: forward-select for one E-stage source operand.
// Ports: rsE (E source reg), rdM/reg_writeM (M writer), rdW/reg_writeW
// (W writer), sel (2-bit forward select, FWD_* encoding).
module fwd_sel_logic #(
    parameter int W = riscv_pipe_pkg::REG_ADDR_W
) (
    input  logic [W-1:0] rsE,
    input  logic [W-1:0] rdM,
    input  logic         reg_writeM,
    input  logic [W-1:0] rdW,
    input  logic         reg_writeW,
    output logic [1:0]   sel
);
    import riscv_pipe_pkg::*;
    // x0 never forwards; the younger M result beats W
    always_comb
        sel = (rsE == '0)                 ? FWD_RD   :
              (reg_writeM && rdM == rsE) ? FWD_FUM  :
              (reg_writeW && rdW == rsE) ? FWD_RESW : FWD_RD;
endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: stall/flush/forward controller for the 5-stage pipeline.
// Inputs: clk, rst_n (sync, active-low), D-stage decode (rs1D, rs2D, rdD,
// reg_writeD, is_loadD, fu_opD) and pc_srcE (taken redirect resolved in E).
// Outputs: forward_op1E/forward_op2E, stallF/D/E, flushD/E/M.
// Optional macro HAZARD_PERF_CNT_EN adds stall_cycles and flush_events.
module hazard_forward_unit #(
    parameter int REG_ADDR_W = riscv_pipe_pkg::REG_ADDR_W,
    parameter int FU_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs1D,
    input  logic [REG_ADDR_W-1:0] rs2D,
    input  logic [REG_ADDR_W-1:0] rdD,
    input  logic                  reg_writeD,
    input  logic                  is_loadD,
    input  logic                  fu_opD,
    input  logic                  pc_srcE,
    output logic [1:0]            forward_op1E,
    output logic [1:0]            forward_op2E,
    output logic                  stallF,
    output logic                  stallD,
    output logic                  stallE,
    output logic                  flushD,
    output logic                  flushE,
    output logic                  flushM
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_events
`endif
);
    import riscv_pipe_pkg::*;
    localparam int CW = $clog2(FU_LATENCY) + 1;
    logic [REG_ADDR_W-1:0] rs1E, rs2E, rdE, rdM, rdW;
    logic                  reg_writeE, is_loadE, fu_opE, reg_writeM, reg_writeW;
    logic [CW-1:0]         mc_cnt;
    logic                  stall_mc, redirect, lu, flush_e, stall_fd;
    logic [1:0]            fwd1, fwd2;
    assign stall_mc = fu_opE && (mc_cnt < CW'(FU_LATENCY - 1));
    // a redirect cannot coexist with an FU stall; if it does, the stall wins
    assign redirect = pc_srcE && !stall_mc;
    assign lu       = is_loadE && reg_writeE && rdE != '0 &&
                      (rdE == rs1D || rdE == rs2D) && !redirect;
    assign flush_e  = redirect || (lu && !stall_mc);
    assign stall_fd = lu || stall_mc;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {rs1E, rs2E, rdE, reg_writeE, is_loadE, fu_opE} <= '0;
            {rdM, reg_writeM, rdW, reg_writeW} <= '0;
            mc_cnt <= '0;
        end else begin
            mc_cnt <= stall_mc ? mc_cnt + CW'(1) : '0;
            if (flush_e)
                {rs1E, rs2E, rdE, reg_writeE, is_loadE, fu_opE} <= '0;
            else if (!stall_mc)
                {rs1E, rs2E, rdE, reg_writeE, is_loadE, fu_opE} <=
                    {rs1D, rs2D, rdD, reg_writeD, is_loadD, fu_opD};
            // E stays occupied during an FU stall, so M receives a bubble
            rdM        <= stall_mc ? '0 : rdE;
            reg_writeM <= !stall_mc && reg_writeE;
            rdW        <= rdM;
            reg_writeW <= reg_writeM;
        end
    end
    fwd_sel_logic #(.W(REG_ADDR_W)) u_fwd1 (
        .rsE(rs1E), .rdM(rdM), .reg_writeM(reg_writeM),
        .rdW(rdW), .reg_writeW(reg_writeW), .sel(fwd1)
    );
    fwd_sel_logic #(.W(REG_ADDR_W)) u_fwd2 (
        .rsE(rs2E), .rdM(rdM), .reg_writeM(reg_writeM),
        .rdW(rdW), .reg_writeW(reg_writeW), .sel(fwd2)
    );
    // every control output is held low while reset is asserted
    assign forward_op1E = rst_n ? fwd1 : FWD_RD;
    assign forward_op2E = rst_n ? fwd2 : FWD_RD;
    assign stallF = rst_n && stall_fd;
    assign stallD = rst_n && stall_fd;
    assign stallE = rst_n && stall_mc;
    assign flushD = rst_n && redirect;
    assign flushE = rst_n && flush_e;
    assign flushM = rst_n && stall_mc;
`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            stall_cycles <= stall_cycles + 32'(stallF);
            flush_events <= flush_events + 32'(flushD);
        end
    end
`endif
endmodule
